// File: rtl/front_panel_encoders.sv
// Multi-channel rotary encoder front panel: debounce, quadrature decode, position counters, event FIFO.
// Define ENC_ACCEL_EN to build per-channel detent-spacing timers that step position by 4 on fast turns.
module front_panel_encoders #(
  parameter int NUM_ENC         = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_W           = 8
`ifdef ENC_ACCEL_EN
  ,
  parameter int ACCEL_WINDOW    = 50000
`endif
) (
  input  logic                        clk,
  input  logic                        spi_reset_n,
  input  logic [NUM_ENC-1:0]          encoder_A,
  input  logic [NUM_ENC-1:0]          encoder_B,
  input  logic [NUM_ENC-1:0]          encoder_sw,
  input  logic                        event_rd_stb,
  output logic [7:0]                  event_reg,
  output logic [$clog2(FIFO_DEPTH):0] event_count,
  output logic                        event_irq,
  output logic [NUM_ENC*CNT_W-1:0]    position,
  input  logic [NUM_ENC-1:0]          pos_clr_stb
);

  localparam int NB    = 3 * NUM_ENC;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge spi_reset_n) begin
    if (!spi_reset_n) rst_pipe <= 2'b00;
    else              rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // Bit layout of the input vectors: [NUM_ENC-1:0] A, then B, then switch.
  logic [NB-1:0]   raw, sync1, sync2, deb, deb_q;
  logic [DB_W-1:0] db_cnt [NB];

  assign raw = {encoder_sw, encoder_B, encoder_A};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  function automatic logic [1:0] cw_next(input logic [1:0] ba);
    case (ba)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  logic [NUM_ENC-1:0] legal, step_cw, detent, ev, last_dir;
  logic [2:0]         ev_word [NUM_ENC];

  // Event word low bits: {switch level, direction, click}.
  always_comb begin
    legal   = '0;
    step_cw = '0;
    detent  = '0;
    ev      = '0;
    for (int n = 0; n < NUM_ENC; n++) begin
      logic [1:0] ab_now, ab_old;
      logic       sw_edge;
      ab_now     = {deb[NUM_ENC + n], deb[n]};
      ab_old     = {deb_q[NUM_ENC + n], deb_q[n]};
      sw_edge    = deb[2*NUM_ENC + n] != deb_q[2*NUM_ENC + n];
      legal[n]   = (ab_now != ab_old) && ((ab_now ^ ab_old) != 2'b11);
      step_cw[n] = ab_now == cw_next(ab_old);
      detent[n]  = legal[n] && (ab_now == 2'b00);
      ev[n]      = legal[n] || sw_edge;
      ev_word[n] = {deb[2*NUM_ENC + n], legal[n] ? step_cw[n] : last_dir[n], detent[n]};
    end
  end

  logic [NUM_ENC-1:0] pend_valid, granted;
  logic [2:0]         pend_data [NUM_ENC];
  logic               grant_valid;
  logic [2:0]         grant_ch, grant_data;
  logic [OCC_W-1:0]   occ, occ_next;
  logic               pop, push, ovf_set, overflow;

  assign pop = event_rd_stb && (occ != '0);

  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = 3'd0;
    grant_data  = 3'd0;
    for (int n = NUM_ENC - 1; n >= 0; n--) begin
      if (pend_valid[n]) begin
        grant_valid = 1'b1;
        grant_ch    = 3'(n);
        grant_data  = pend_data[n];
      end
    end
  end

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign push = grant_valid && ((occ != OCC_W'(FIFO_DEPTH)) || pop);

  always_comb begin
    granted = '0;
    for (int n = 0; n < NUM_ENC; n++) granted[n] = push && (grant_ch == 3'(n));
  end

  assign ovf_set = |(ev & pend_valid & ~granted);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= '0;
      last_dir   <= '0;
      for (int n = 0; n < NUM_ENC; n++) pend_data[n] <= 3'd0;
    end else begin
      for (int n = 0; n < NUM_ENC; n++) begin
        if (ev[n]) begin
          pend_valid[n] <= 1'b1;
          pend_data[n]  <= ev_word[n];
        end else if (granted[n]) begin
          pend_valid[n] <= 1'b0;
        end
        if (legal[n]) last_dir[n] <= step_cw[n];
      end
    end
  end

  logic [5:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_comb begin
    occ_next = occ;
    if (push && !pop)      occ_next = occ + OCC_W'(1);
    else if (pop && !push) occ_next = occ - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {grant_ch, grant_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      event_irq <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ       <= occ_next;
      event_irq <= occ_next != '0;
      if (ovf_set)  overflow <= 1'b1;
      else if (pop) overflow <= 1'b0;
    end
  end

  assign event_reg   = (occ == '0) ? 8'h00 : {1'b1, overflow, mem[rd_ptr]};
  assign event_count = occ;

  logic [CNT_W-1:0] pos      [NUM_ENC];
  logic [CNT_W-1:0] step_mag [NUM_ENC];

`ifdef ENC_ACCEL_EN
  localparam int ACC_W = $clog2(ACCEL_WINDOW + 1);

  logic [ACC_W-1:0] gap_tmr [NUM_ENC];

  // Timers start saturated so the first detent after reset is a normal single step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_ENC; n++) gap_tmr[n] <= ACC_W'(ACCEL_WINDOW);
    end else begin
      for (int n = 0; n < NUM_ENC; n++) begin
        if (detent[n])                                gap_tmr[n] <= '0;
        else if (gap_tmr[n] != ACC_W'(ACCEL_WINDOW)) gap_tmr[n] <= gap_tmr[n] + ACC_W'(1);
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_ENC; n++)
      step_mag[n] = (gap_tmr[n] < ACC_W'(ACCEL_WINDOW)) ? CNT_W'(4) : CNT_W'(1);
  end
`else
  always_comb begin
    for (int n = 0; n < NUM_ENC; n++) step_mag[n] = CNT_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_ENC; n++) pos[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_ENC; n++) begin
        if (pos_clr_stb[n])  pos[n] <= '0;
        else if (detent[n])  pos[n] <= step_cw[n] ? pos[n] + step_mag[n] : pos[n] - step_mag[n];
      end
    end
  end

  always_comb begin
    position = '0;
    for (int n = 0; n < NUM_ENC; n++) position[n*CNT_W +: CNT_W] = pos[n];
  end

endmodule

// File: doc/front_panel_encoders.md
Name: front_panel_encoders

Overview:
Multi-channel front-panel rotary encoder controller, the parametrised successor to the single-encoder front-panel block. Each channel synchronises, debounces and quadrature-decodes its A/B/switch inputs and keeps a per-channel position counter. Events from all channels are merged through a fixed-priority arbiter into an event FIFO. The CPU pops the FIFO via the SPI register interface, and an interrupt-style flag shows pending events.

Parameters:
NUM_ENC, 2, encoder channels, 1..8
DEBOUNCE_CYCLES, 1000, cycles an input must be stable before it is accepted, >=2
FIFO_DEPTH, 8, event FIFO entries, power of 2, >=2
CNT_W, 8, per-channel position counter width
ACCEL_WINDOW, 50000, detent spacing in cycles below which acceleration applies (used only with ENC_ACCEL_EN)

Ports:
clk  in  1  system clock
spi_reset_n  in  1  asynchronous active-low reset
encoder_A  in  NUM_ENC  raw A phase per channel
encoder_B  in  NUM_ENC  raw B phase per channel
encoder_sw  in  NUM_ENC  raw push switch per channel, 1 = pressed
event_rd_stb  in  1  one-cycle pop of the FIFO head
event_reg  out  8  FIFO head word: [0] click, [1] clkwise, [2] switch, [5:3] channel, [6] overflow, [7] valid
event_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
event_irq  out  1  high while FIFO is non-empty
position  out  NUM_ENC*CNT_W  packed per-channel counters; channel n occupies [n*CNT_W +: CNT_W]
pos_clr_stb  in  NUM_ENC  one-cycle clear, one bit per channel

Behaviour:
- Reset (async assert, sync release via 2-FF on spi_reset_n):
  - All outputs are 0; position is 0, FIFO is empty, overflow is clear.
  - Debounced states load 2'b00 and switch 0.
- Input path per bit:
  - 2-FF synchroniser, then a debounce counter.
  - The counter reloads on any change of the synchronised value.
  - The debounced value updates once the input has been stable for DEBOUNCE_CYCLES.
  - Input-to-debounced latency is 2+DEBOUNCE_CYCLES cycles.
- Quadrature decode, on debounced {B,A}:
  - Clockwise sequence is 00->01->11->10->00; counter-clockwise is 00->10->11->01->00.
  - A single-step change is a legal step: it raises the channel step strobe, clkwise=direction, click=1 when the new state is 00 (detent).
  - A two-bit change (00<->11, 01<->10) is illegal: the state updates, no event is raised, the position is unchanged.
- Switch: each debounced edge of sw raises a channel event with click=0, clkwise=last direction, switch=new value.
- Position:
  - Signed two's complement.
  - +1 on a clockwise detent, -1 on a counter-clockwise detent; wraps modulo 2^CNT_W.
  - pos_clr_stb[n] has priority over a same-cycle detent; the result is 0.
- Arbitration:
  - Each channel has a 1-deep pending register.
  - Each cycle the lowest-index pending channel is written into the FIFO, if not full.
  - A new event on a channel whose pending register is still occupied overwrites it and sets sticky overflow.
- FIFO:
  - Write happens the cycle after the pending register loads, giving 2 cycles from step strobe to valid at the head.
  - Full: the write is refused and the event stays pending (back-pressure into pending).
  - Empty: event_reg reads 0 (valid=0); event_rd_stb has no effect.
  - Simultaneous read and write when full: both occur and the count is unchanged.
  - Simultaneous read and write when empty: the write lands and the count becomes 1.
- Overflow:
  - event_reg[6] shows sticky overflow OR'd into the head word.
  - event_rd_stb clears overflow in the same cycle it pops, unless a new overflow occurs that cycle; the new overflow wins.
- event_irq equals (event_count != 0), registered.
- Channel field: for NUM_ENC < 8, unused channel codes never appear; event_reg[5:3] carries the channel index zero-extended.

Optional Feature:
ENC_ACCEL_EN
- Defined:
  - Each channel has a free-running detent-spacing timer, saturating at ACCEL_WINDOW.
  - A detent arriving while the timer is below ACCEL_WINDOW steps position by +/-4; otherwise by +/-1.
  - The timer resets on every detent. The event word is unchanged.
- Undefined: no timer is built and position always steps by 1.

Test Plan:
- Reset: NUM_ENC=2, DEBOUNCE_CYCLES=4; hold spi_reset_n=0 with random inputs -> event_reg=0, event_count=0, event_irq=0, position=0.
- Clockwise detent: ch0 BA 00->01->11->10->00, each held 10 cycles -> 4 events ch0 clkwise=1, last with click=1; position[0]=1, position[1]=0.
- Bounce and illegal step: ch1 A toggles every 2 cycles for 20 cycles, then BA 00->11 -> no events, position[1]=0.
- Simultaneous events: ch0 and ch1 switch presses on the same cycle -> FIFO holds ch0 then ch1 entries with switch=1, overflow=0.
- FIFO full and overflow: FIFO_DEPTH=4, 6 ch0 steps with no reads -> count=4; pending overwrite sets head[6]=1; one event_rd_stb pops, clears overflow, and the pending event enters the FIFO.
- Wrap and clear: 256 counter-clockwise detents on ch0 with CNT_W=8 -> position[0]=0 (via 0xFF after the first); a pos_clr_stb[0] on a detent cycle gives 0.
